// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encodings and the bit-counter width helper
// used by the bit-serial arithmetic blocks.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int ARITH_WIDTH_MIN = 2;
    localparam int ARITH_WIDTH_MAX = 32;

    // Bits needed to count 0..width-1; never narrower than one bit.
    function automatic int cnt_bits(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: difference and borrow-out of x - y.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) behind a start/done handshake.
// Define SERIAL_SUB_CMP_EN to add registered lt/eq/gt comparison flags.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_CMP_EN
    ,
    output logic             lt,
    output logic             eq,
    output logic             gt
`endif
);

    localparam int CW = cnt_bits(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] sh_d_q, sh_d_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bin_q, bin_d;
    logic             borrow_q, borrow_d;
    logic             done_q, done_d;

    logic             hs0_d, hs0_bo, hs1_bo;
    logic             slice_d, slice_bout;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] sh_d_shifted;

    // Full subtractor slice: two half subtractors, borrows ORed.
    half_subtractor u_hs0 (
        .x  (sh_a_q[0]),
        .y  (sh_b_q[0]),
        .d  (hs0_d),
        .bo (hs0_bo)
    );

    half_subtractor u_hs1 (
        .x  (hs0_d),
        .y  (bin_q),
        .d  (slice_d),
        .bo (hs1_bo)
    );

    assign slice_bout   = hs0_bo | hs1_bo;
    assign last_bit     = (cnt_q == CW'(WIDTH - 1));
    assign accept       = (state_q == ST_IDLE) && start;
    assign sh_d_shifted = {slice_d, {(WIDTH-1){1'b0}}} | (sh_d_q >> 1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start)    state_d = ST_RUN;
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            ST_DONE:               state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q == ST_RUN);
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        sh_d_d   = sh_d_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;

        if (accept) begin
            sh_a_d = a;
            sh_b_d = b;
            bin_d  = 1'b0;
            cnt_d  = '0;
        end else if (state_q == ST_RUN) begin
            sh_a_d = sh_a_q >> 1;
            sh_b_d = sh_b_q >> 1;
            sh_d_d = sh_d_shifted;
            bin_d  = slice_bout;
            cnt_d  = cnt_q + CW'(1);
            // Result registers only move at completion so they hold across the next run.
            if (last_bit) begin
                diff_d   = sh_d_shifted;
                borrow_d = slice_bout;
                done_d   = 1'b1;
            end
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            sh_d_q   <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            sh_d_q   <= sh_d_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
        end
    end

    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

`ifdef SERIAL_SUB_CMP_EN
    logic nz_q, nz_d;
    logic lt_q, lt_d;
    logic eq_q, eq_d;
    logic gt_q, gt_d;

    // nz_q accumulates an OR of every produced difference bit of the current run.
    always_comb begin
        nz_d = nz_q;
        lt_d = lt_q;
        eq_d = eq_q;
        gt_d = gt_q;
        if (accept) begin
            nz_d = 1'b0;
        end else if (state_q == ST_RUN) begin
            nz_d = nz_q | slice_d;
            if (last_bit) begin
                lt_d = slice_bout;
                eq_d = ~(nz_q | slice_d);
                gt_d = ~slice_bout & (nz_q | slice_d);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nz_q <= 1'b0;
            lt_q <= 1'b0;
            eq_q <= 1'b0;
            gt_q <= 1'b0;
        end else begin
            nz_q <= nz_d;
            lt_q <= lt_d;
            eq_q <= eq_d;
            gt_q <= gt_d;
        end
    end

    assign lt = lt_q;
    assign eq = eq_q;
    assign gt = gt_q;
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- Built from a half-subtractor pair with a registered borrow; it is the inverse-operation companion to the team's half-adder arithmetic blocks.
- Sits as a small arithmetic slave behind a start/done handshake.
- Trades latency (N cycles) for area: one bit-slice plus shift registers.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk     input   1      rising-edge clock
- rst_n   input   1      asynchronous active-low reset
- start   input   1      request; sampled only in IDLE
- a       input   WIDTH  minuend; captured on the accepted start
- b       input   WIDTH  subtrahend; captured on the accepted start
- busy    output  1      high while an operation is in progress (RUN)
- done    output  1      single-cycle pulse; diff/borrow valid
- diff    output  WIDTH  a - b modulo 2^WIDTH; held until next accepted start
- borrow  output  1      final borrow-out; 1 when a < b unsigned; held with diff

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow=0, bit counter=0, internal borrow=0, operand shift registers=0.
- States are IDLE, RUN and DONE, encoded in 2 bits.
- IDLE:
  - When start=1 at a rising edge, capture a into sh_a and b into sh_b, clear the borrow flop and the counter, and go to RUN.
  - With start=0, stay in IDLE.
- RUN (busy=1), one slice per edge using sh_a[0], sh_b[0] and bin:
  - d = a0^b0^bin
  - bout = (~a0 & b0) | (~(a0^b0) & bin)
  - Shift sh_a and sh_b right by 1.
  - Shift d into the MSB of the diff shift register.
  - bin <= bout; cnt <= cnt+1.
- RUN exit: at the edge that processes bit WIDTH-1 (cnt==WIDTH-1), go to DONE.
  - That same edge loads the final diff and sets borrow to that edge's bout.
  - done is registered and goes high at the same edge.
- DONE (one cycle):
  - done=1, busy=0.
  - The next edge returns to IDLE unconditionally and clears done.
- Latency:
  - The edge that samples start is edge 0.
  - done is high in the cycle after edge WIDTH.
  - Back-to-back throughput is one result per WIDTH+2 cycles.
- Start handling:
  - start in RUN or DONE is ignored, not queued.
  - start may be held high continuously; a new operation begins on the first IDLE edge with start=1.
- Output stability:
  - diff/borrow are not valid while busy=1. The diff shift register may expose partial bits; the verifier checks only when done=1 and afterwards in IDLE.
  - After done, diff/borrow hold until the next accepted start. The accepted start does not clear them; they update only at completion.
- a and b may change freely after capture; they have no effect until the next accepted start.
- Arithmetic wrap-around: 0 - 1 gives diff = all ones, borrow=1. a==b gives 0, borrow=0.
- Reset mid-operation: async return to reset values immediately; the partial result is discarded and no done pulse is issued.

Optional Feature:
- Macro: SERIAL_SUB_CMP_EN.
- When defined, three extra outputs are added, each 1 bit:
  - lt: equals borrow.
  - eq: 1 when all diff bits are 0.
  - gt: ~lt & ~eq.
- The comparison flags follow these rules:
  - All three are registered and updated in the same edge as diff/borrow.
  - All three reset to 0.
  - All three hold with diff.
  - eq is computed by an OR-accumulator over produced d bits during RUN, not by a WIDTH-wide reduction.
- When undefined:
  - The ports and logic are absent.
  - Behaviour is otherwise identical.

Decomposition:
- Shared package/include `arith_pkg`:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Counter-width helper constant (clog2 of WIDTH).
- Sub-module `half_subtractor`:
  - Ports: x, y -> d = x^y, bo = ~x&y.
  - Instantiated twice to form the bit-slice full subtractor; the two bo outputs are ORed to give bout.

Test Plan:
- Reset, then a=8'h05, b=8'h03, start one cycle: busy high 8 cycles; done pulses in the cycle after edge 8; diff=8'h02, borrow=0 (CMP: gt=1).
- a=8'h03, b=8'h05: diff=8'hFE, borrow=1 (CMP: lt=1); values hold for 20 idle cycles after done.
- Boundaries:
  - a=8'h00, b=8'h01 gives diff=8'hFF, borrow=1.
  - a=8'hFF, b=8'hFF gives diff=8'h00, borrow=0 (CMP: eq=1).
  - a=8'h80, b=8'h7F gives diff=8'h01, borrow=0.
- Start pulses during RUN and DONE are ignored:
  - Only one done is produced.
  - A held start yields back-to-back ops spaced WIDTH+2 cycles apart.
  - a/b changes after capture do not alter the result.
- Assert rst_n low at cnt=4 of an op: outputs go to 0 immediately (async) with no done; a subsequent op (a=8'h10, b=8'h01) gives diff=8'h0F.
- Random sweep of 1000 pairs at WIDTH=8 and WIDTH=13 against a reference model, checking diff and borrow at done.
